// File: rtl/dma_engine.sv
// dma_engine: single-channel DRAM<->SRAM word copier that holds the core via stall while copying.
// Latency: D2S 2 cycles/word, S2D 3 cycles/word best case, then one DONE cycle with dmaValid.
// Backpressure: each DRAM request is held level until dramValid; the SRAM side never stalls.
module dma_engine #(
    parameter int SRAM_AW = 14,
    parameter int DRAM_AW = 32,
    parameter int DW      = 32,
    parameter int LEN_W   = 10,
    parameter int STRIDE  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         cmd,
    input  logic [31:0]        srcAddress,
    input  logic [31:0]        dstAddress,
    input  logic [LEN_W-1:0]   width,
    output logic [SRAM_AW-1:0] sramAddress,
    output logic [DW-1:0]      sramWriteData,
    output logic               sramWriteEnable,
    input  logic [DW-1:0]      sramReadData,
    output logic [DRAM_AW-1:0] dramAddress,
    output logic [DW-1:0]      dramWriteData,
    output logic               dramReadEnable,
    output logic               dramWriteEnable,
    input  logic [DW-1:0]      dramReadData,
    input  logic               dramValid,
    output logic               stall,
    output logic               dmaValid
);

    typedef enum logic [2:0] {
        IDLE, D2S_RD, D2S_WR, S2D_RD, S2D_CAP, S2D_WR, DONE
    } state_t;

    localparam logic [1:0]         CMD_D2S   = 2'b01;
    localparam logic [1:0]         CMD_S2D   = 2'b10;
    localparam logic [SRAM_AW-1:0] SRAM_STEP = SRAM_AW'(STRIDE);
    localparam logic [DRAM_AW-1:0] DRAM_STEP = DRAM_AW'(STRIDE);

    state_t             state;
    logic [SRAM_AW-1:0] cur_sram;
    logic [DRAM_AW-1:0] cur_dram;
    logic [LEN_W-1:0]   remaining;
    logic [DW-1:0]      data_q;
    logic               start;
    logic               last_word;

    assign start     = (state == IDLE) && (cmd == CMD_D2S || cmd == CMD_S2D);
    assign last_word = (remaining == LEN_W'(1));

    // Held from the command cycle itself; reset forces it low along with everything else.
    assign stall = !reset && (start || (state != IDLE && state != DONE));

    assign sramWriteData = sramWriteEnable ? data_q : '0;
    assign dramWriteData = dramWriteEnable ? data_q : '0;

    // Output registers are loaded with the values belonging to the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cur_sram        <= '0;
            cur_dram        <= '0;
            remaining       <= '0;
            data_q          <= '0;
            sramAddress     <= '0;
            sramWriteEnable <= 1'b0;
            dramAddress     <= '0;
            dramReadEnable  <= 1'b0;
            dramWriteEnable <= 1'b0;
            dmaValid        <= 1'b0;
        end else begin
            sramAddress     <= '0;
            sramWriteEnable <= 1'b0;
            dramAddress     <= '0;
            dramReadEnable  <= 1'b0;
            dramWriteEnable <= 1'b0;
            dmaValid        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= width;
                        if (cmd == CMD_D2S) begin
                            cur_dram <= srcAddress[DRAM_AW-1:0];
                            cur_sram <= dstAddress[SRAM_AW-1:0];
                        end else begin
                            cur_sram <= srcAddress[SRAM_AW-1:0];
                            cur_dram <= dstAddress[DRAM_AW-1:0];
                        end
                        if (width == '0) begin
                            state    <= DONE;
                            dmaValid <= 1'b1;
                        end else if (cmd == CMD_D2S) begin
                            state          <= D2S_RD;
                            dramAddress    <= srcAddress[DRAM_AW-1:0];
                            dramReadEnable <= 1'b1;
                        end else begin
                            state       <= S2D_RD;
                            sramAddress <= srcAddress[SRAM_AW-1:0];
                        end
                    end
                end
                D2S_RD: begin
                    if (dramValid) begin
                        data_q          <= dramReadData;
                        state           <= D2S_WR;
                        sramAddress     <= cur_sram;
                        sramWriteEnable <= 1'b1;
                    end else begin
                        dramAddress    <= cur_dram;
                        dramReadEnable <= 1'b1;
                    end
                end
                D2S_WR: begin
                    remaining <= remaining - LEN_W'(1);
                    cur_sram  <= cur_sram + SRAM_STEP;
                    cur_dram  <= cur_dram + DRAM_STEP;
                    if (last_word) begin
                        state    <= DONE;
                        dmaValid <= 1'b1;
                    end else begin
                        state          <= D2S_RD;
                        dramAddress    <= cur_dram + DRAM_STEP;
                        dramReadEnable <= 1'b1;
                    end
                end
                S2D_RD: begin
                    state <= S2D_CAP;
                end
                S2D_CAP: begin
                    data_q          <= sramReadData;
                    state           <= S2D_WR;
                    dramAddress     <= cur_dram;
                    dramWriteEnable <= 1'b1;
                end
                S2D_WR: begin
                    if (dramValid) begin
                        remaining <= remaining - LEN_W'(1);
                        cur_sram  <= cur_sram + SRAM_STEP;
                        cur_dram  <= cur_dram + DRAM_STEP;
                        if (last_word) begin
                            state    <= DONE;
                            dmaValid <= 1'b1;
                        end else begin
                            state       <= S2D_RD;
                            sramAddress <= cur_sram + SRAM_STEP;
                        end
                    end else begin
                        dramAddress     <= cur_dram;
                        dramWriteEnable <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_engine.sv
// Randomized bench for dma_engine: SRAM/DRAM memory models, a delay-programmable DRAM responder,
// and a transfer-level reference model that predicts every strobe and the completion cycle.
module tb_dma_engine;

    localparam int LEN_W = 10;
    localparam logic [31:0] SMASK = 32'h0000_3FFF;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        cmd = 2'b00;
    logic [31:0]       srcAddress = '0;
    logic [31:0]       dstAddress = '0;
    logic [LEN_W-1:0]  width = '0;
    logic [13:0]       sramAddress;
    logic [31:0]       sramWriteData;
    logic              sramWriteEnable;
    logic [31:0]       sramReadData = '0;
    logic [31:0]       dramAddress;
    logic [31:0]       dramWriteData;
    logic              dramReadEnable;
    logic              dramWriteEnable;
    logic [31:0]       dramReadData = '0;
    logic              dramValid = 1'b0;
    logic              stall;
    logic              dmaValid;

    dma_engine dut (
        .clk(clk), .reset(reset), .cmd(cmd),
        .srcAddress(srcAddress), .dstAddress(dstAddress), .width(width),
        .sramAddress(sramAddress), .sramWriteData(sramWriteData),
        .sramWriteEnable(sramWriteEnable), .sramReadData(sramReadData),
        .dramAddress(dramAddress), .dramWriteData(dramWriteData),
        .dramReadEnable(dramReadEnable), .dramWriteEnable(dramWriteEnable),
        .dramReadData(dramReadData), .dramValid(dramValid),
        .stall(stall), .dmaValid(dmaValid)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] sram_mem [logic [31:0]];
    logic [31:0] dram_mem [logic [31:0]];

    function automatic logic [31:0] sram_val(input logic [31:0] a);
        logic [31:0] k;
        k = a & SMASK;
        if (sram_mem.exists(k)) return sram_mem[k];
        return (k * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] dram_val(input logic [31:0] a);
        if (dram_mem.exists(a)) return dram_mem[a];
        return (a * 32'h85EB_CA6B) ^ 32'hC0FF_EE00;
    endfunction

    // Memory side: synchronous SRAM (data one cycle after address) and DRAM that answers
    // after dram_delay extra request cycles; dramValid is noise when nothing is requested.
    int          dram_delay = 0;
    int          wait_cnt = 0;
    logic [31:0] prev_saddr = '0;

    always @(negedge clk) begin
        sramReadData = sram_val(prev_saddr);
        prev_saddr   = {18'b0, sramAddress};
        if (sramWriteEnable) sram_mem[{18'b0, sramAddress}] = sramWriteData;
        if (!reset && (dramReadEnable || dramWriteEnable)) begin
            if (wait_cnt >= dram_delay) begin
                dramValid = 1'b1;
                wait_cnt  = 0;
                if (dramReadEnable) dramReadData = dram_val(dramAddress);
                else dram_mem[dramAddress] = dramWriteData;
            end else begin
                dramValid    = 1'b0;
                wait_cnt++;
                dramReadData = $urandom;
            end
        end else begin
            dramValid    = 1'($urandom_range(0, 1));
            wait_cnt     = 0;
            dramReadData = $urandom;
        end
    end

    logic [63:0] exp_sw[$], obs_sw[$], exp_dw[$], obs_dw[$];
    logic [31:0] exp_rd[$], obs_rd[$];

    task automatic run_xfer(input logic [1:0] c, input logic [31:0] src, input logic [31:0] dst,
                            input int w, input int dly, input bit toggle);
        int done_idx, dv_cnt, dv_idx, stall_err, inv_err;
        logic [31:0] sa, da;
        exp_sw.delete(); obs_sw.delete(); exp_dw.delete(); obs_dw.delete();
        exp_rd.delete(); obs_rd.delete();
        dv_cnt = 0; dv_idx = -1; stall_err = 0; inv_err = 0;
        dram_delay = dly;
        if (w == 0) done_idx = 1;
        else if (c == 2'b01) done_idx = 1 + w * (dly + 2);
        else done_idx = 1 + w * (dly + 3);
        for (int i = 0; i < w; i++) begin
            if (c == 2'b01) begin
                sa = src + 32'(4 * i);
                da = (dst + 32'(4 * i)) & SMASK;
                for (int k = 0; k <= dly; k++) exp_rd.push_back(sa);
                exp_sw.push_back({da, dram_val(sa)});
            end else begin
                sa = (src + 32'(4 * i)) & SMASK;
                da = dst + 32'(4 * i);
                for (int k = 0; k <= dly; k++) exp_dw.push_back({da, sram_val(sa)});
            end
        end
        @(negedge clk);
        cmd = c; srcAddress = src; dstAddress = dst; width = LEN_W'(w);
        for (int cyc = 0; cyc < done_idx + 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (stall !== (cyc < done_idx)) stall_err++;
            if ((dramReadEnable && dramWriteEnable) ||
                (sramWriteEnable && (dramReadEnable || dramWriteEnable))) inv_err++;
            if (sramWriteEnable) obs_sw.push_back({18'b0, sramAddress, sramWriteData});
            if (dramReadEnable) obs_rd.push_back(dramAddress);
            if (dramWriteEnable) obs_dw.push_back({dramAddress, dramWriteData});
            if (dmaValid) begin dv_cnt++; dv_idx = cyc; end
            if (cyc >= 1) begin
                srcAddress = $urandom; dstAddress = $urandom; width = LEN_W'($urandom);
                if (!toggle) cmd = 2'b00;
                else if (cyc >= 2) cmd = (cyc < done_idx - 2) ? 2'b10 : 2'b00;
            end
        end
        check_eq("dmaValid_count", dv_cnt, 1);
        check_eq("dmaValid_cycle", dv_idx, done_idx);
        check_eq("stall_profile_errs", stall_err, 0);
        check_eq("enable_exclusive_errs", inv_err, 0);
        check_eq("sram_wr_count", obs_sw.size(), exp_sw.size());
        for (int i = 0; i < exp_sw.size() && i < obs_sw.size(); i++)
            check_eq("sram_wr_addr_data", obs_sw[i], exp_sw[i]);
        check_eq("dram_rd_cycles", obs_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
            check_eq("dram_rd_addr", obs_rd[i], exp_rd[i]);
        check_eq("dram_wr_cycles", obs_dw.size(), exp_dw.size());
        for (int i = 0; i < exp_dw.size() && i < obs_dw.size(); i++)
            check_eq("dram_wr_addr_data", obs_dw[i], exp_dw[i]);
    endtask

    function automatic logic any_out();
        return |{sramAddress, sramWriteData, sramWriteEnable, dramAddress, dramWriteData,
                 dramReadEnable, dramWriteEnable, stall, dmaValid};
    endfunction

    initial begin
        int errs;
        bit found;
        logic [1:0] rc;
        // power-on reset
        #2 reset = 1'b1;
        #1 check_eq("reset_outputs", any_out(), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 check_eq("post_reset_idle", any_out(), 0);

        run_xfer(2'b01, 32'h0000_1000, 32'h0000_0040, 3, 0, 1'b0);
        check_eq("d2s_first_sram_addr", obs_sw.size() > 0 ? obs_sw[0][63:32] : 64'hDEAD, 32'h40);

        sram_mem[32'h100] = 32'hAAAA_5555;
        sram_mem[32'h104] = 32'h1234_5678;
        run_xfer(2'b10, 32'h0000_0100, 32'h0000_2000, 2, 2, 1'b0);
        check_eq("s2d_dram_word0", dram_val(32'h2000), 32'hAAAA_5555);
        check_eq("s2d_dram_word1", dram_val(32'h2004), 32'h1234_5678);

        run_xfer(2'b01, 32'h0000_5000, 32'h0000_0200, 2, 5, 1'b0);
        run_xfer(2'b01, 32'h0000_6000, 32'h0000_0300, 0, 0, 1'b0);

        // reserved command: no stall, no completion, no strobes
        errs = 0;
        @(negedge clk);
        cmd = 2'b11; width = 10'd3;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (any_out()) errs++;
        end
        cmd = 2'b00;
        check_eq("reserved_cmd_quiet", errs, 0);

        // reset while an S2D write request is being held
        dram_delay = 3;
        @(negedge clk);
        cmd = 2'b10; srcAddress = 32'h200; dstAddress = 32'h4000; width = 10'd4;
        found = 1'b0;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            @(negedge clk); #1;
            cmd = 2'b00;
            if (dramWriteEnable) found = 1'b1;
        end
        check_eq("reached_s2d_wr", found, 1);
        #1 reset = 1'b1;
        #1 check_eq("async_reset_outputs", any_out(), 0);
        cmd = 2'b01;
        #1 check_eq("reset_stall_low", stall, 0);
        cmd = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        check_eq("abandoned_write", dram_mem.exists(32'h4000), 0);
        run_xfer(2'b01, 32'h0000_3000, 32'h0000_0080, 1, 0, 1'b0);

        // SRAM address wrap with a mid-transfer command change
        run_xfer(2'b01, 32'h0000_7000, 32'h0000_3FFC, 2, 0, 1'b1);
        check_eq("sram_wrap_addr", obs_sw.size() > 1 ? obs_sw[1][63:32] : 64'hDEAD, 0);

        run_xfer(2'b10, 32'h0000_3FF8, 32'hFFFF_FFF8, 3, 1, 1'b0);

        for (int t = 0; t < 20; t++) begin
            rc = 2'($urandom_range(1, 2));
            run_xfer(rc, $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
